// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority per bit,
// optional parity, 1 or 2 stop bits, valid/ready output with overrun pulse.
module uart_rx_param #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 rx_i,
    input  logic                 en_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int unsigned HALF = CLK_PER_BIT / 2;
    localparam int unsigned BCW  = $clog2(CLK_PER_BIT);
    localparam int unsigned IW   = $clog2(DATA_BITS);

    localparam logic [BCW-1:0] BC_EARLY = BCW'(HALF - 1);
    localparam logic [BCW-1:0] BC_MID   = BCW'(HALF);
    localparam logic [BCW-1:0] BC_RES   = BCW'(HALF + 1);
    localparam logic [BCW-1:0] BC_LAST  = BCW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0]  IDX_LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]  IDX_LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic           ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  armed_q, armed_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [IW-1:0]         bidx_q, bidx_d;
    logic [1:0]            smp_q, smp_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    logic rxs, bitv, resolve, wrap, done, ferr_fin;

    assign rxs     = sync_q[1];
    // 2-of-3 vote: two registered early samples plus the live third sample
    assign bitv    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign resolve = (bcnt_q == BC_RES);
    assign wrap    = (bcnt_q == BC_LAST);

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        bcnt_d      = bcnt_q;
        bidx_d      = bidx_q;
        smp_d       = smp_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = 1'b0;
        done        = 1'b0;
        ferr_fin    = ferr_pend_q;

        if (valid_q && ready_i) valid_d = 1'b0;

        if (state_q != IDLE) begin
            bcnt_d = wrap ? '0 : bcnt_q + 1'b1;
            if (bcnt_q == BC_EARLY) smp_d[0] = rxs;
            if (bcnt_q == BC_MID)   smp_d[1] = rxs;
        end

        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (rxs) armed_d = 1'b1;
                if (en_i && armed_q && !rxs) begin
                    state_d     = START;
                    armed_d     = 1'b0;
                    par_d       = 1'b0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
                // a false start must win over the wrap when both coincide
                if (resolve && bitv) state_d = IDLE;
            end
            DATA: begin
                if (resolve) begin
                    shreg_d = {bitv, shreg_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ bitv;
                end
                if (wrap) begin
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == IDX_LAST_DATA) begin
                        bidx_d  = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (resolve && (bitv != (par_q ^ ODD))) perr_pend_d = 1'b1;
                if (wrap) begin
                    state_d = STOP;
                    bidx_d  = '0;
                end
            end
            STOP: begin
                if (wrap) bidx_d = bidx_q + 1'b1;
                if (resolve) begin
                    ferr_fin    = ferr_pend_q | ~bitv;
                    ferr_pend_d = ferr_fin;
                    if (bidx_q == IDX_LAST_STOP) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                perr_d  = perr_pend_q;
                ferr_d  = ferr_fin;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            armed_q     <= 1'b0;
            bcnt_q      <= '0;
            bidx_q      <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rx_i};
            armed_q     <= armed_d;
            bcnt_q      <= bcnt_d;
            bidx_q      <= bidx_d;
            smp_q       <= smp_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != IDLE);

endmodule
